// File: rtl/bit4_shift.sv
// bit4_shift: four-stage serial-in/serial-out delay line with async active-low clear.
// The output D is the last stage register itself, so data on `in` leaves three
// edges after it is captured into A.
module bit4_shift (
    input  logic in,
    input  logic clk,
    input  logic clr,
    output logic D
);

    // Intermediate stages; named so they can be probed hierarchically.
    logic A;
    logic B;
    logic C;

    // Shift A -> B -> C -> D every rising edge; clear zeroes all stages at once.
    // X/Z on `in` is captured as-is; clear is the only way to recover from it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            A <= 1'b0;
            B <= 1'b0;
            C <= 1'b0;
            D <= 1'b0;
        end else begin
            A <= in;
            B <= A;
            C <= B;
            D <= C;
        end
    end

endmodule

// File: tb/tb_bit4_shift.sv
// tb_bit4_shift: directed and random stimulus for bit4_shift, checked against a
// queue-based delay-line model of the last four captured bits.
module tb_bit4_shift;

    logic clk;
    logic clr;
    logic in;
    logic D;

    int checks   = 0;
    int failures = 0;

    // Model: most recently captured bit at index 0, oldest (output) at index 3.
    logic hist[$];

    bit4_shift u_dut (
        .in  (in),
        .clk (clk),
        .clr (clr),
        .D   (D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A"}, u_dut.A, hist[0]);
        chk({tag, ".B"}, u_dut.B, hist[1]);
        chk({tag, ".C"}, u_dut.C, hist[2]);
        chk({tag, ".D"}, D,       hist[3]);
    endtask

    task automatic model_clear();
        hist = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // Drive `in`, take one rising edge, update the model, check 1 time unit later.
    task automatic tick(input logic v, input string tag);
        in = v;
        @(posedge clk);
        if (clr === 1'b1) begin
            hist.push_front(v);
            hist = hist[0:3];
        end
        #1;
        check_all(tag);
    endtask

    // Clear pulse strictly between edges; stages must be zero before any edge.
    task automatic clear_pulse(input string tag);
        #2;
        clr = 1'b0;
        model_clear();
        #1;
        check_all(tag);
        #1;
        clr = 1'b1;
    endtask

    initial begin
        // Asynchronous clear with no clock edge involved.
        in  = 1'b0;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        model_clear();
        #1;
        check_all("async_clr");
        #4;
        clr = 1'b1;
        #1;
        check_all("clr_release");

        // Single-bit ripple: one 1 followed by zeros.
        tick(1'b1, "ripple");
        for (int i = 0; i < 5; i++) tick(1'b0, "ripple");

        // Alternating pattern.
        for (int i = 0; i < 10; i++) tick(logic'(i % 2 == 0), "alt");

        // Clear dominates clock edges while held low.
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) tick(1'b1, "clr_hold");
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, "clr_rel_shift");

        // Mid-stream clear with A,B,C,D = 1,1,0,1.
        tick(1'b1, "load");
        tick(1'b0, "load");
        tick(1'b1, "load");
        tick(1'b1, "load");
        chk("load_pattern", D, 1'b1);
        clear_pulse("mid_clr");
        for (int i = 0; i < 4; i++) tick(1'b0, "after_mid_clr");

        // X propagation, then recovery by clear.
        tick(1'bx, "x_in");
        for (int i = 0; i < 3; i++) tick(1'b0, "x_prop");
        chk("x_at_D", D, 1'bx);
        tick(1'b0, "x_out");
        clear_pulse("x_clr");

        // Random serial data with occasional clear pulses.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) clear_pulse("rnd_clr");
            else tick(logic'($urandom_range(0, 1)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
